// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB master sequencer (IDLE -> SETUP -> ACCESS) for two slaves.
//   Latches a command on transfer and decodes PADDR[AW-1] into PSEL1/PSEL2.
//   It muxes the selected slave's response back to the command side.
// Ports:
//   pclk, presetn             - clock, asynchronous active-low reset
//   transfer, READ_WRITE      - command request, 1=read / 0=write
//   apb_read_paddr/_write_*   - command address/data
//   apb_read_data_out         - data of the last completed read
//   busy, xfer_done, pslverr_out - status (busy in SETUP/ACCESS, 1-cycle done pulse, last error)
//   PADDR..PENABLE            - APB request outputs (all registered)
//   PREADYx, PRDATAx, PSLVERRx - slave responses, x=1 when PADDR[AW-1]=0, x=2 otherwise
// Optional: define APB_TIMEOUT_EN to abort a transfer after TIMEOUT_CYCLES ACCESS cycles
//   with no ready. When it is undefined, ACCESS waits indefinitely.
module apb_master_ctrl #(
  parameter int AW             = 9,
  parameter int DW             = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          transfer,
  input  logic          READ_WRITE,
  input  logic [AW-1:0] apb_read_paddr,
  input  logic [AW-1:0] apb_write_paddr,
  input  logic [DW-1:0] apb_write_data,
  output logic [DW-1:0] apb_read_data_out,
  output logic          busy,
  output logic          xfer_done,
  output logic          pslverr_out,
  output logic [AW-1:0] PADDR,
  output logic          PWRITE,
  output logic [DW-1:0] PWDATA,
  output logic          PSEL1,
  output logic          PSEL2,
  output logic          PENABLE,
  input  logic          PREADY1,
  input  logic          PREADY2,
  input  logic [DW-1:0] PRDATA1,
  input  logic [DW-1:0] PRDATA2,
  input  logic          PSLVERR1,
  input  logic          PSLVERR2
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic          pwrite_q, pwrite_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          psel1_q, psel1_d;
  logic          psel2_q, psel2_d;
  logic          penable_q, penable_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // Response mux keyed on the latched address, so the unselected slave is ignored.
  logic          sel;
  logic          rdy;
  logic          slverr;
  logic [DW-1:0] prdata;
  logic          timeout_hit;

  assign sel    = paddr_q[AW-1];
  assign rdy    = sel ? PREADY2  : PREADY1;
  assign slverr = sel ? PSLVERR2 : PSLVERR1;
  assign prdata = sel ? PRDATA2  : PRDATA1;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_q;

  // wait_cnt_q counts completed no-ready ACCESS cycles; the edge that would make
  // it reach TIMEOUT_CYCLES is the abort edge. A ready on that edge still wins.
  assign timeout_hit = (state_q == S_ACCESS) && !rdy &&
                       (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_SETUP) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_ACCESS && !rdy) begin
      wait_cnt_q <= wait_cnt_q + CW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    logic start;
    logic finish;
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    psel1_d   = psel1_q;
    psel2_d   = psel2_q;
    penable_d = penable_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    start     = 1'b0;
    finish    = 1'b0;

    case (state_q)
      S_IDLE: begin
        start = transfer;
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        finish = rdy | timeout_hit;
        if (finish) begin
          done_d = 1'b1;
          err_d  = rdy ? slverr : 1'b1;
          if (rdy && !pwrite_q) begin
            rdata_d = prdata;
          end
          if (transfer) begin
            start = 1'b1;
          end else begin
            state_d   = S_IDLE;
            psel1_d   = 1'b0;
            psel2_d   = 1'b0;
            penable_d = 1'b0;
            busy_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Command latch, shared by IDLE start and back-to-back restart from ACCESS.
    if (start) begin
      state_d   = S_SETUP;
      paddr_d   = READ_WRITE ? apb_read_paddr : apb_write_paddr;
      pwrite_d  = ~READ_WRITE;
      if (!READ_WRITE) begin
        pwdata_d = apb_write_data;
      end
      psel1_d   = ~paddr_d[AW-1];
      psel2_d   = paddr_d[AW-1];
      penable_d = 1'b0;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel2_d;
      penable_q <= penable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign PADDR             = paddr_q;
  assign PWRITE            = pwrite_q;
  assign PWDATA            = pwdata_q;
  assign PSEL1             = psel1_q;
  assign PSEL2             = psel2_q;
  assign PENABLE           = penable_q;
  assign busy              = busy_q;
  assign xfer_done         = done_q;
  assign pslverr_out       = err_q;
  assign apb_read_data_out = rdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed stimulus for apb_master_ctrl with a transaction-level
//   reference model compared on every cycle, plus literal spot checks.
module tb_apb_master_ctrl;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic          transfer = 1'b0;
  logic          READ_WRITE = 1'b0;
  logic [AW-1:0] apb_read_paddr = '0;
  logic [AW-1:0] apb_write_paddr = '0;
  logic [DW-1:0] apb_write_data = '0;
  logic [DW-1:0] apb_read_data_out;
  logic          busy, xfer_done, pslverr_out;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PSEL1, PSEL2, PENABLE;
  logic          PREADY1 = 1'b0, PREADY2 = 1'b0;
  logic [DW-1:0] PRDATA1 = '0, PRDATA2 = '0;
  logic          PSLVERR1 = 1'b0, PSLVERR2 = 1'b0;

  apb_master_ctrl #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .presetn(presetn), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_read_paddr(apb_read_paddr), .apb_write_paddr(apb_write_paddr),
    .apb_write_data(apb_write_data), .apb_read_data_out(apb_read_data_out),
    .busy(busy), .xfer_done(xfer_done), .pslverr_out(pslverr_out),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE),
    .PREADY1(PREADY1), .PREADY2(PREADY2), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
    .PSLVERR1(PSLVERR1), .PSLVERR2(PSLVERR2)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // m_active: a transfer is in flight; m_acc: ACCESS cycles entered so far (0 = SETUP).
  bit            m_active = 0;
  int            m_acc = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_write = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_err = 1'b0;
  logic          m_done = 1'b0;
  logic          m_rdy, m_serr;
  logic [DW-1:0] m_prd;
  bit            m_end, m_abort;

  task automatic m_start();
    m_active = 1;
    m_acc    = 0;
    m_write  = !READ_WRITE;
    m_addr   = READ_WRITE ? apb_read_paddr : apb_write_paddr;
    if (!READ_WRITE) m_wdata = apb_write_data;
  endtask

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m_active = 0; m_acc = 0; m_addr = '0; m_write = 0; m_wdata = '0;
      m_rdata = '0; m_err = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (transfer) m_start();
      end else if (m_acc == 0) begin
        m_acc = 1;
      end else begin
        m_rdy  = m_addr[AW-1] ? PREADY2  : PREADY1;
        m_serr = m_addr[AW-1] ? PSLVERR2 : PSLVERR1;
        m_prd  = m_addr[AW-1] ? PRDATA2  : PRDATA1;
        m_abort = 0;
`ifdef APB_TIMEOUT_EN
        m_abort = !m_rdy && (m_acc == TO);
`endif
        m_end = m_rdy || m_abort;
        if (m_end) begin
          m_done = 1;
          m_err  = m_rdy ? m_serr : 1'b1;
          if (m_rdy && !m_write) m_rdata = m_prd;
          if (transfer) m_start();
          else m_active = 0;
        end else begin
          m_acc++;
        end
      end
    end
  end

  logic [31:0] dut_vec, exp_vec;
  assign dut_vec = {apb_read_data_out, busy, xfer_done, pslverr_out, PADDR, PWRITE, PWDATA,
                    PSEL1, PSEL2, PENABLE};
  assign exp_vec = {m_rdata, m_active, m_done, m_err, m_addr, m_write, m_wdata,
                    m_active && !m_addr[AW-1], m_active && m_addr[AW-1],
                    m_active && (m_acc > 0)};

  always @(posedge pclk) begin
    #1;
    chk("cycle_model", dut_vec, exp_vec);
  end

  task automatic tick();
    @(posedge pclk);
    #2;
  endtask

  int acc_cnt;

  initial begin
    // Reset state
    tick();
    chk("reset_outputs", dut_vec, 32'h0);
    presetn = 1'b1;
    tick();

    // Write to slave 1, no wait states
    transfer = 1; READ_WRITE = 0; apb_write_paddr = 9'h012; apb_write_data = 8'hA5;
    PREADY1 = 1; PREADY2 = 0;
    tick();
    chk("wr1_setup_psel1", PSEL1, 1);
    chk("wr1_setup_penable", PENABLE, 0);
    chk("wr1_paddr", PADDR, 9'h012);
    chk("wr1_pwdata", PWDATA, 8'hA5);
    transfer = 0;
    tick();
    chk("wr1_access_penable", PENABLE, 1);
    chk("wr1_psel2", PSEL2, 0);
    tick();
    chk("wr1_done", xfer_done, 1);
    chk("wr1_idle_busy", busy, 0);
    tick();
    chk("wr1_done_once", xfer_done, 0);

    // Read slave 2 with three wait states; command inputs wiggle mid-transfer
    transfer = 1; READ_WRITE = 1; apb_read_paddr = 9'h105; PRDATA2 = 8'h3C; PREADY2 = 0;
    PRDATA1 = 8'hFF;
    tick();
    chk("rd2_psel2", PSEL2, 1);
    chk("rd2_psel1", PSEL1, 0);
    chk("rd2_pwdata_held", PWDATA, 8'hA5);
    transfer = 0; apb_read_paddr = 9'h0FF; READ_WRITE = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd2_wait_penable", PENABLE, 1);
      chk("rd2_wait_paddr", PADDR, 9'h105);
    end
    PREADY2 = 1;
    tick();
    chk("rd2_done", xfer_done, 1);
    chk("rd2_rdata", apb_read_data_out, 8'h3C);

    // Back-to-back write 0x020 then read 0x120
    transfer = 1; READ_WRITE = 0; apb_write_paddr = 9'h020; apb_write_data = 8'h5A;
    apb_read_paddr = 9'h120; PREADY1 = 1; PREADY2 = 1; PRDATA2 = 8'h77;
    tick();
    chk("b2b_first_psel1", PSEL1, 1);
    READ_WRITE = 1;
    tick();
    chk("b2b_first_penable", PENABLE, 1);
    tick();
    chk("b2b_second_setup", {PSEL1, PSEL2, PENABLE, xfer_done, busy}, 5'b01011);
    chk("b2b_second_paddr", PADDR, 9'h120);
    transfer = 0;
    tick();
    chk("b2b_second_penable", PENABLE, 1);
    tick();
    chk("b2b_rdata", apb_read_data_out, 8'h77);

    // Error on a read of slave 1, then a clean write clears it
    transfer = 1; READ_WRITE = 1; apb_read_paddr = 9'h030; PRDATA1 = 8'hC3;
    PSLVERR1 = 1; PREADY1 = 1;
    tick(); transfer = 0; tick(); tick();
    chk("err_flag", pslverr_out, 1);
    chk("err_rdata", apb_read_data_out, 8'hC3);
    PSLVERR1 = 0; PSLVERR2 = 1;
    transfer = 1; READ_WRITE = 0; apb_write_paddr = 9'h040; apb_write_data = 8'h11;
    tick(); transfer = 0; tick(); tick();
    chk("clean_flag", pslverr_out, 0);
    chk("clean_rdata_held", apb_read_data_out, 8'hC3);
    PSLVERR2 = 0;
    tick();

`ifdef APB_TIMEOUT_EN
    // Slave 1 never ready: abort after TO ACCESS cycles
    PREADY1 = 0; PRDATA1 = 8'hEE;
    transfer = 1; READ_WRITE = 1; apb_read_paddr = 9'h011;
    tick(); transfer = 0;
    acc_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (xfer_done) break;
      if (PENABLE) acc_cnt++;
    end
    chk("to_done", xfer_done, 1);
    chk("to_access_cycles", acc_cnt, TO);
    chk("to_err", pslverr_out, 1);
    chk("to_rdata_held", apb_read_data_out, 8'hC3);
    PREADY1 = 1;
    tick();
`endif

    // Reset in the middle of ACCESS on slave 2
    transfer = 1; READ_WRITE = 1; apb_read_paddr = 9'h1AB; PREADY2 = 0;
    tick(); transfer = 0; tick(); tick();
    chk("rst_pre_penable", PENABLE, 1);
    #1 presetn = 0;
    #1;
    chk("rst_async_outputs", dut_vec, 32'h0);
    tick();
    presetn = 1; PREADY2 = 1;
    tick(); tick();
    chk("rst_after_idle", {busy, xfer_done, PSEL2, PENABLE}, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- APB master sequencer driven by the bench-side command interface: transfer, READ_WRITE, apb_read_paddr, apb_write_paddr, apb_write_data and apb_read_data_out.
- Runs the IDLE/SETUP/ACCESS protocol and decodes the address MSB into two slave selects.
- Muxes the two slaves' response buses and returns read data and error/done status to the command side.
- Sits between the testbench driver/monitor and the two APB slaves.

Parameters:
- AW, 9, address width; bit AW-1 selects the slave.
- DW, 8, data width.
- TIMEOUT_CYCLES, 16, maximum wait-state count before abort (used only with APB_TIMEOUT_EN).

Ports:
- pclk  in  1  clock
- presetn  in  1  asynchronous active-low reset
- transfer  in  1  command request
- READ_WRITE  in  1  1=read, 0=write
- apb_read_paddr  in  AW  read address
- apb_write_paddr  in  AW  write address
- apb_write_data  in  DW  write data
- apb_read_data_out  out  DW  last completed read data
- busy  out  1  transfer in progress (SETUP or ACCESS)
- xfer_done  out  1  one-cycle completion pulse
- pslverr_out  out  1  error status of last completed transfer
- PADDR  out  AW  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DW  APB write data
- PSEL1  out  1  select, slave 1
- PSEL2  out  1  select, slave 2
- PENABLE  out  1  APB enable
- PREADY1, PREADY2  in  1  slave ready
- PRDATA1, PRDATA2  in  DW  slave read data
- PSLVERR1, PSLVERR2  in  1  slave error

Behaviour:
- Clocking and reset:
  - All outputs are registered.
  - Reset (presetn=0) forces IDLE immediately; every output is 0.
  - Reset mid-transfer drops PSELx/PENABLE in the same instant. No completion is reported.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - PSELx=0, PENABLE=0, busy=0.
  - transfer=1 at posedge -> SETUP. On that edge, latch the command:
    - PWRITE = ~READ_WRITE.
    - PADDR = READ_WRITE ? apb_read_paddr : apb_write_paddr.
    - PWDATA = apb_write_data. For reads, PWDATA holds its previous value.
- SETUP (exactly 1 cycle):
  - PSEL1 = ~PADDR[AW-1], PSEL2 = PADDR[AW-1], PENABLE=0, busy=1.
  - Always -> ACCESS.
- ACCESS:
  - PENABLE=1; PSELx held.
  - Selected ready/data/error: sel = PADDR[AW-1]; rdy/prdata/slverr come from slave 2 when sel=1, slave 1 otherwise.
  - rdy=0: stay in ACCESS (wait state); all APB outputs stable.
  - rdy=1 (completion edge):
    - Register xfer_done=1 for the next cycle only.
    - pslverr_out = slverr.
    - On a read, apb_read_data_out = prdata. On a write, apb_read_data_out is unchanged.
    - If transfer=1, latch a new command and go directly to SETUP (back-to-back; PENABLE drops to 0 and PSELx are recomputed).
    - Otherwise go to IDLE; PSELx and PENABLE are 0.
- Command inputs are ignored outside the latch edges. Changes during SETUP/ACCESS have no effect.
- PADDR/PWRITE/PWDATA hold their last values in IDLE; they are not cleared.
- pslverr_out and apb_read_data_out hold until the next completion.
- The unselected slave's PREADY/PRDATA/PSLVERR have no effect.
- Minimum transfer: 2 cycles (SETUP + 1 ACCESS); N wait states give 2+N cycles.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on SETUP and increments each ACCESS cycle with rdy=0.
  - If it reaches TIMEOUT_CYCLES, the transfer aborts with the same next-state rules as completion.
  - On abort: xfer_done pulses, pslverr_out=1, apb_read_data_out unchanged.
  - rdy=1 on the same edge as the limit wins (normal completion).
- Not defined: no counter; ACCESS waits indefinitely for rdy. TIMEOUT_CYCLES is unused.

Test Plan:
- Write slave 1: transfer=1, READ_WRITE=0, write_paddr=0x012, wdata=0xA5, PREADY1=1 -> SETUP with PSEL1=1, PENABLE=0; next cycle PENABLE=1; xfer_done pulses at cycle 3; PSEL2 stays 0.
- Read slave 2 with wait states: read_paddr=0x105, PRDATA2=0x3C, PREADY2 low 3 ACCESS cycles -> ACCESS lasts 4 cycles with PADDR stable; apb_read_data_out=0x3C; PSEL1 stays 0.
- Back-to-back: transfer held 1 across write 0x020 and read 0x120 -> no IDLE cycle; PSEL1 then PSEL2; PENABLE low for exactly one cycle between transfers.
- Error: PSLVERR1=1 at completion of a read of 0x030 -> pslverr_out=1, data captured; next clean write -> pslverr_out=0.
- Reset mid-ACCESS: presetn=0 while PREADY2=0 -> all outputs 0 asynchronously, no xfer_done; after release with transfer=0, stays IDLE.
- APB_TIMEOUT_EN: PREADY1 never asserted, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles; pslverr_out=1, xfer_done=1, apb_read_data_out unchanged.
